// File: rtl/g_root_lut_gen_if.sv
// Write-side bundle between the LUT generator (master) and the LUT RAM (slave).
`timescale 1ns/1ps
interface g_root_lut_gen_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/g_root_lut_gen.sv
// Builds the gradient LUT at runtime: entry a = (2**DATA_W-1) - floor(sqrt(a << SCALE_SHIFT)),
// one restoring square-root iteration per cycle, each entry pushed through a valid/ready port.
`timescale 1ns/1ps
module g_root_lut_gen #(
   parameter int ADDR_W      = 13,
   parameter int DATA_W      = 8,
   parameter int SCALE_SHIFT = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   g_root_lut_gen_if.master        wr
);
   localparam int RAD_W = 2 * DATA_W;
   localparam int REM_W = DATA_W + 2;
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WRITE, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [RAD_W-1:0]  r_rad;
   logic [REM_W-1:0]  r_rem;
   logic [DATA_W-1:0] r_root;
   logic [DATA_W-1:0] r_wr_data;
   logic [CNT_W-1:0]  r_cnt;

   logic [RAD_W-1:0]  w_rad_load;
   logic [REM_W+1:0]  w_rem_sh;
   logic [REM_W+1:0]  w_trial;
   logic              w_ge;
   logic [DATA_W-1:0] w_root_nxt;
   logic              w_last;

   assign w_rad_load = RAD_W'(r_addr) << SCALE_SHIFT;
   assign w_rem_sh   = {r_rem, r_rad[RAD_W-1 -: 2]};
   assign w_trial    = {2'b00, r_root, 2'b01};
   assign w_ge       = (w_rem_sh >= w_trial);
   assign w_root_nxt = {r_root[DATA_W-2:0], w_ge};
   assign w_last     = (r_addr == {ADDR_W{1'b1}});

   assign wr.wr_addr = r_addr;
   assign wr.wr_data = r_wr_data;

   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge, so it also overrides a start in the same cycle.
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: every output gets a default up front so no path through the case infers a latch.
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      wr.wr_valid = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            done = (r_state == S_DONE);
            if (start) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            busy        = 1'b1;
            w_state_nxt = S_CALC;
         end
         S_CALC: begin
            busy = 1'b1;
            if (r_cnt == '0) w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            busy        = 1'b1;
            wr.wr_valid = 1'b1;
            if (wr.wr_ready) w_state_nxt = w_last ? S_DONE : S_LOAD;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: the remainder never needs more than DATA_W+2 bits before its next shift.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (!rst_n) begin
         r_addr    <= '0;
         r_rad     <= '0;
         r_rem     <= '0;
         r_root    <= '0;
         r_cnt     <= '0;
         r_wr_data <= '0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start) r_addr <= '0;
            end
            S_LOAD: begin
               r_rad  <= w_rad_load;
               r_rem  <= '0;
               r_root <= '0;
               r_cnt  <= CNT_W'(DATA_W - 1);
            end
            S_CALC: begin
               r_rad  <= r_rad << 2;
               r_rem  <= REM_W'(w_ge ? (w_rem_sh - w_trial) : w_rem_sh);
               r_root <= w_root_nxt;
               r_cnt  <= r_cnt - 1'b1;
               if (r_cnt == '0) r_wr_data <= ~w_root_nxt;
            end
            S_WRITE: begin
               if (wr.wr_ready && !w_last) r_addr <= r_addr + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_g_root_lut_gen.sv
// Directed bench: a default-size generator sweeps its full table while a 512-entry instance
// is exercised for backpressure, ignored start, mid-sweep reset and restart from done.
`timescale 1ns/1ps
module tb_g_root_lut_gen;
   localparam int B_AW = 13;
   localparam int S_AW = 9;
   localparam int DW   = 8;
   localparam int SS   = 3;

   logic clk = 1'b0;
   logic b_rst_n, b_start, b_busy, b_done;
   logic s_rst_n, s_start, s_busy, s_done;

   int n_vec = 0;
   int n_err = 0;
   int b_exp, b_cnt, b_cyc;
   int s_exp, s_cnt;

   always #5 clk = ~clk;

   g_root_lut_gen_if #(.ADDR_W(B_AW), .DATA_W(DW)) b_if ();
   g_root_lut_gen_if #(.ADDR_W(S_AW), .DATA_W(DW)) s_if ();

   g_root_lut_gen #(.ADDR_W(B_AW), .DATA_W(DW), .SCALE_SHIFT(SS)) u_big (
      .clk(clk), .rst_n(b_rst_n), .start(b_start), .busy(b_busy), .done(b_done), .wr(b_if.master)
   );
   g_root_lut_gen #(.ADDR_W(S_AW), .DATA_W(DW), .SCALE_SHIFT(SS)) u_small (
      .clk(clk), .rst_n(s_rst_n), .start(s_start), .busy(s_busy), .done(s_done), .wr(s_if.master)
   );

   function automatic int isqrt(input int x);
      int r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   function automatic int model(input int a);
      return 255 - isqrt(a * 8);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_s_valid(input string tag);
      int n = 0;
      while (!s_if.wr_valid && n < 40) begin
         step();
         n++;
      end
      check(tag, s_if.wr_valid, 1);
   endtask

   initial begin
      int  n;
      bit  t4;
      int  t1_hand [5];
      t1_hand = '{255, 253, 251, 251, 250};
      b_rst_n = 0; s_rst_n = 0; b_start = 0; s_start = 0;
      b_if.wr_ready = 1; s_if.wr_ready = 0;
      b_exp = 0; b_cnt = 0; b_cyc = 0; s_exp = 0; s_cnt = 0;

      fork
         forever begin
            @(negedge clk);
            if (b_busy) b_cyc++;
            if (b_if.wr_valid && b_if.wr_ready) begin
               check("big_addr", b_if.wr_addr, b_exp);
               check("big_data", b_if.wr_data, model(b_exp));
               check("big_busy_done_on_write", {b_busy, b_done}, 2'b10);
               case (int'(b_if.wr_addr))
                  0:    check("t1_a0",    b_if.wr_data, 255);
                  1:    check("t1_a1",    b_if.wr_data, 253);
                  2:    check("t1_a2",    b_if.wr_data, 251);
                  32:   check("t1_a32",   b_if.wr_data, 239);
                  8191: check("t1_a8191", b_if.wr_data, 0);
                  default: ;
               endcase
               b_exp++;
               b_cnt++;
            end
         end
         forever begin
            @(negedge clk);
            if (!s_rst_n) begin
               s_exp = 0;
               s_cnt = 0;
            end else if (s_if.wr_valid && s_if.wr_ready) begin
               check("small_addr", s_if.wr_addr, s_exp);
               check("small_data", s_if.wr_data, model(s_exp));
               s_exp++;
               s_cnt++;
            end
         end
      join_none

      step(); step();
      s_start = 1; step(); s_start = 0; step();
      check("rst_s_busy",  s_busy, 0);
      check("rst_s_done",  s_done, 0);
      check("rst_s_valid", s_if.wr_valid, 0);
      check("rst_s_addr",  s_if.wr_addr, 0);
      check("rst_s_data",  s_if.wr_data, 0);
      check("rst_b_state", {b_busy, b_done, b_if.wr_valid}, 0);
      check("rst_b_bus",   {b_if.wr_addr, b_if.wr_data}, 0);
      b_rst_n = 1; s_rst_n = 1; step();
      check("start_under_reset_dropped", {s_busy, s_done}, 0);

      b_start = 1; s_start = 1; step(); b_start = 0; s_start = 0;
      check("b_busy_after_start", {b_busy, b_done}, 2'b10);
      check("s_busy_after_start", {s_busy, s_done}, 2'b10);

      for (int a = 0; a < 5; a++) begin
         wait_s_valid("s_valid_lead");
         check("s_addr_lead", s_if.wr_addr, a);
         check("s_data_lead", s_if.wr_data, t1_hand[a]);
         s_if.wr_ready = 1; step(); s_if.wr_ready = 0;
         check("s_valid_drop", s_if.wr_valid, 0);
      end

      wait_s_valid("s_valid_a5");
      for (int c = 0; c < 5; c++) begin
         check("bp_valid", s_if.wr_valid, 1);
         check("bp_addr",  s_if.wr_addr, 5);
         check("bp_data",  s_if.wr_data, 249);
         step();
      end
      check("bp_hold_after_5", {s_if.wr_valid, s_if.wr_addr}, {1'b1, 9'd5});
      check("bp_no_write_yet", s_cnt, 5);
      s_if.wr_ready = 1; step(); s_if.wr_ready = 0;
      check("bp_single_write", s_cnt, 6);
      check("bp_valid_drop", s_if.wr_valid, 0);

      t4 = 0; n = 0;
      while (!s_done && n < 20000) begin
         if (!t4 && s_if.wr_addr == 100) begin
            s_start = 1;
            t4 = 1;
         end else begin
            s_start = 0;
         end
         s_if.wr_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      s_start = 0;
      check("t4_start_pulsed", t4, 1);
      check("rand_done", {s_busy, s_done}, 2'b01);
      check("rand_count", s_cnt, 512);
      check("rand_last_addr", s_if.wr_addr, 511);
      s_if.wr_ready = 1;
      repeat (10) step();
      check("done_no_extra_write", s_cnt, 512);
      check("done_held", {s_done, s_if.wr_valid}, 2'b10);

      s_exp = 0; s_cnt = 0;
      s_start = 1; step(); s_start = 0;
      check("t6_restart", {s_busy, s_done}, 2'b10);
      wait_s_valid("t6_valid");
      check("t6_first", {s_if.wr_addr, s_if.wr_data}, {9'd0, 8'd255});

      n = 0;
      while (s_if.wr_addr != 300 && n < 4000) begin
         step();
         n++;
      end
      check("t5_reach_300", s_if.wr_addr, 300);
      check("t5_count_before", s_cnt, 300);
      s_rst_n = 0; step();
      check("t5_state", {s_busy, s_done, s_if.wr_valid}, 0);
      check("t5_bus", {s_if.wr_addr, s_if.wr_data}, 0);
      s_rst_n = 1;
      repeat (12) step();
      check("t5_quiet", {s_cnt, 1'b0, s_if.wr_valid, s_busy}, 0);
      s_start = 1; step(); s_start = 0;
      wait_s_valid("t5_rebuild_valid");
      check("t5_rebuild_first", {s_if.wr_addr, s_if.wr_data}, {9'd0, 8'd255});
      n = 0;
      while (s_cnt < 3 && n < 60) begin
         step();
         n++;
      end
      check("t5_rebuild_order", s_exp, 3);

      n = 0;
      while (!b_done && n < 100000) begin
         step();
         n++;
      end
      check("t2_done", {b_busy, b_done}, 2'b01);
      check("t2_count", b_cnt, 8192);
      check("t2_cycles", b_cyc, 81920);
      check("t2_last_addr", b_if.wr_addr, 8191);
      repeat (10) step();
      check("t2_no_write_after", b_cnt, 8192);
      check("t2_idle_after", {b_done, b_if.wr_valid}, 2'b10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
